// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-ROM request/response, redirect and decode-side valid/ready bundle.
// Latency: none (wires only). Backpressure: out_ready from decode, honoured by the fetch stage.
// Ports: master = fetch stage (drives imem_addr/imem_rd/out_*), slave = ROM + decode + branch unit.
// Optional IF_PERF_CNT_EN adds fetch_cnt/stall_cnt, driven by the master.
interface instr_fetch_if #(
  parameter int PC_W = 12
);
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd;
  logic [31:0]     imem_q;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            out_ready;
  logic            out_valid;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      opcode;
  logic [4:0]      ALUop;
`ifdef IF_PERF_CNT_EN
  logic [31:0]     fetch_cnt;
  logic [31:0]     stall_cnt;
`endif

  modport master (
    output imem_addr, imem_rd,
    input  imem_q,
    input  redirect, redirect_pc,
    input  out_ready,
    output out_valid, out_instr, out_pc, opcode, ALUop
`ifdef IF_PERF_CNT_EN
    , output fetch_cnt, stall_cnt
`endif
  );

  modport slave (
    input  imem_addr, imem_rd,
    output imem_q,
    output redirect, redirect_pc,
    output out_ready,
    input  out_valid, out_instr, out_pc, opcode, ALUop
`ifdef IF_PERF_CNT_EN
    , input fetch_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: holds the PC, requests the synchronous instruction ROM and hands words + PC to decode.
// Latency: request in cycle t, ROM word on imem_q in t+1, registered onto out_* for t+2; 1 instr/cycle.
// Backpressure: output register plus one skid entry; requests throttled so nothing is lost on stall.
// Ports: clock, reset (async active-high), bus (instr_fetch_if.master: imem_*, redirect*, out_*,
// opcode, ALUop). Define IF_PERF_CNT_EN to add the fetch_cnt/stall_cnt performance counters.
module instr_fetch #(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t          state;
  logic [PC_W-1:0] fetch_pc;
  logic            inflight;
  logic [PC_W-1:0] inflight_pc;
  logic            drop;
  logic            out_valid_q;
  logic [31:0]     out_instr_q;
  logic [PC_W-1:0] out_pc_q;
  logic            skid_valid;
  logic [31:0]     skid_instr;
  logic [PC_W-1:0] skid_pc;

  logic       consume;
  logic       out_free;
  logic       issue;
  logic       ret;
  logic [1:0] occ;
  logic [1:0] occ_after;

  assign consume   = out_valid_q & bus.out_ready;
  assign out_free  = ~out_valid_q | bus.out_ready;
  // Words held or owed to decode; at most 3 (output + skid + one in flight).
  assign occ       = {1'b0, out_valid_q} + {1'b0, skid_valid} + {1'b0, inflight};
  assign occ_after = occ - {1'b0, consume};
  // A new request must still have a slot when it returns, even if decode stalls from now on.
  // DRAIN is a bookkeeping state only, so the redirect target is fetched the very next cycle.
  assign issue     = (state != BOOT) && !bus.redirect && (occ_after < 2'd2);
  // drop marks the cycle right after a flush; no ROM response is accepted while it is set.
  assign ret       = inflight & ~drop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      drop        <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
    end else begin
      inflight <= issue;
      drop     <= 1'b0;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end
      if (bus.redirect) begin
        // Flush wins over everything: the word on out_* (even if accepted this cycle), the skid
        // entry and the ROM word arriving now are all discarded.
        out_valid_q <= 1'b0;
        skid_valid  <= 1'b0;
        fetch_pc    <= bus.redirect_pc;
        drop        <= inflight;
        state       <= inflight ? DRAIN : RUN;
      end else begin
        state <= RUN;
        if (out_free) begin
          if (skid_valid) begin
            // Skid is older than any returning word, so it goes out first.
            out_valid_q <= 1'b1;
            out_instr_q <= skid_instr;
            out_pc_q    <= skid_pc;
            skid_valid  <= ret;
            if (ret) begin
              skid_instr <= bus.imem_q;
              skid_pc    <= inflight_pc;
            end
          end else if (ret) begin
            out_valid_q <= 1'b1;
            out_instr_q <= bus.imem_q;
            out_pc_q    <= inflight_pc;
          end else begin
            out_valid_q <= 1'b0;
          end
        end else if (ret) begin
          // Output stalled: the issue throttle guarantees the skid is empty here.
          skid_valid <= 1'b1;
          skid_instr <= bus.imem_q;
          skid_pc    <= inflight_pc;
        end
      end
    end
  end

  // imem_rd is combinational because the ROM address and strobe belong to the same cycle.
  assign bus.imem_addr = fetch_pc;
  assign bus.imem_rd   = issue;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.opcode    = out_instr_q[31:27];
  assign bus.ALUop     = out_instr_q[6:2];

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (consume)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (out_valid_q && !bus.out_ready)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt = fetch_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: drives instr_fetch with a synchronous ROM model, random stalls and redirects.
// Reference: the expected next PC of the in-order instruction stream, advanced on each accepted
// word and reloaded on redirect/reset; every presented word is compared against ROM[expected PC].
module tb_instr_fetch;
  localparam int PC_W = 12;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  instr_fetch_if #(.PC_W(PC_W)) bus ();

  instr_fetch #(.PC_W(PC_W), .RESET_PC(12'h000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] rom [0:(1<<PC_W)-1];

  // Synchronous ROM: address/strobe sampled on the edge, word visible the following cycle.
  always @(posedge clock)
    if (bus.imem_rd) bus.imem_q <= rom[bus.imem_addr];

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_pc;
  int          idle;
  bit          held;
  bit          after_redir;
  bit          stream_chk;
  int          xfers;
  int          perf_f;
  int          perf_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a falling edge: check what decode sees now, then drive inputs for the next edge.
  task automatic cycle(input bit rdy, input bit redir, input logic [11:0] rpc);
    logic [31:0] w;
    if (after_redir) chk("flush", bus.out_valid, 32'd0);
    if (held)        chk("hold", bus.out_valid, 32'd1);
    if (stream_chk)  chk("thru", bus.out_valid, 32'd1);
    if (bus.out_valid) begin
      idle = 0;
      w = rom[exp_pc];
      chk("pc", bus.out_pc, exp_pc);
      chk("instr", bus.out_instr, w);
      chk("opcode", bus.opcode, w[31:27]);
      chk("aluop", bus.ALUop, w[6:2]);
    end else begin
      idle++;
      if (idle == 5) chk("live", idle, 32'd4);
    end
    bus.out_ready   = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    if (bus.out_valid && rdy)  perf_f++;
    if (bus.out_valid && !rdy) perf_s++;
    after_redir = redir;
    held        = bus.out_valid && !rdy && !redir;
    if (redir) begin
      exp_pc = rpc;
      idle   = 0;
    end else if (bus.out_valid && rdy) begin
      exp_pc = exp_pc + 12'd1;
      xfers++;
    end
    @(negedge clock);
  endtask

  // Reset is high on entry; release it and follow the first fetch: BOOT (cycle 0),
  // request in cycle 1, ROM word in cycle 2, first out_valid in cycle 3.
  task automatic boot();
    logic [31:0] w;
    bus.out_ready = 1'b1;
    bus.redirect  = 1'b0;
    reset         = 1'b0;
    exp_pc = 12'h000; idle = 0; held = 0; after_redir = 0; stream_chk = 0;
    perf_f = 0; perf_s = 0;
    @(negedge clock);
    chk("req_rd", bus.imem_rd, 32'd1);
    chk("req_addr", bus.imem_addr, 32'h000);
    @(negedge clock);
    chk("lat_early", bus.out_valid, 32'd0);
    @(negedge clock);
    chk("lat", bus.out_valid, 32'd1);
    w = rom[0];
    chk("opc0", bus.opcode, 32'h05);
    chk("alu0", bus.ALUop, 32'h05);
    chk("opc0_rom", {27'd0, w[31:27]}, 32'h05);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << PC_W); i++) rom[i] = 32'h0800_0000 | i;
    rom[0] = 32'h2842_0014;
    bus.imem_q      = '0;
    bus.out_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    xfers = 0;

    // Reset state.
    @(negedge clock);
    @(negedge clock);
    chk("rst_valid", bus.out_valid, 32'd0);
    chk("rst_rd", bus.imem_rd, 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_opcode", bus.opcode, 32'd0);
    chk("rst_aluop", bus.ALUop, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);

    boot();
    stream_chk = 1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 12'h0);  // PCs 0..5 back to back
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 12'h0);  // 3-cycle stall
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 12'h0);

    // Redirect with a word in flight; the in-flight word must never appear.
    stream_chk = 0;
    cycle(1'b1, 1'b1, 12'h040);
    cycle(1'b1, 1'b0, 12'h0);
    cycle(1'b1, 1'b0, 12'h0);
    stream_chk = 1;
    chk("redir_pc", bus.out_pc, 32'h040);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 12'h0);

    // PC wrap: 0xFFE, 0xFFF, 0x000, 0x001.
    stream_chk = 0;
    cycle(1'b1, 1'b1, 12'hFFE);
    cycle(1'b1, 1'b0, 12'h0);
    cycle(1'b1, 1'b0, 12'h0);
    stream_chk = 1;
    chk("wrap_pc", bus.out_pc, 32'hFFE);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 12'h0);
    stream_chk = 0;

    // Random stalls and redirects.
    for (int i = 0; i < 1500; i++) begin
      logic [11:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (12'hFF0 | 12'($urandom_range(0, 15))) : 12'($urandom);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, rpc);
    end
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt_run", bus.fetch_cnt, perf_f);
    chk("stall_cnt_run", bus.stall_cnt, perf_s);
`endif

    // Asynchronous reset mid-stream clears the output at once.
    bus.out_ready = 1'b1;
    bus.redirect  = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 32'd0);
    chk("arst_rd", bus.imem_rd, 32'd0);
    chk("arst_addr", bus.imem_addr, 32'h000);
    @(negedge clock);
    @(negedge clock);
    boot();

    // 5 transfers and 3 stall cycles after reset.
    cycle(1'b1, 1'b0, 12'h0);
    cycle(1'b1, 1'b0, 12'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 12'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 12'h0);
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", bus.fetch_cnt, 32'd5);
    chk("stall_cnt", bus.stall_cnt, 32'd3);
`endif
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 12'h0);

    chk("progress", {31'd0, (xfers > 500)}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
